// File: rtl/branch_target_buffer_if.sv
// Fetch/predict and branch-feedback bundle of the branch target buffer.
// master: frontend / branch unit side; slave: the branch target buffer.
interface branch_target_buffer_if #(
    parameter int AWIDTH = 30
);
    logic              fetch_valid;
    logic [AWIDTH-1:0] fetch_pc;
    logic              pred_valid;
    logic              predicted_taken;
    logic [AWIDTH-1:0] pred_target;
    logic              ready;
    logic              fb_taken;
    logic              fb_not_taken;
    logic [AWIDTH-1:0] fb_pc;
    logic [AWIDTH-1:0] fb_target;

    modport master (
        output fetch_valid, fetch_pc, fb_taken, fb_not_taken, fb_pc, fb_target,
        input  pred_valid, predicted_taken, pred_target, ready
    );

    modport slave (
        input  fetch_valid, fetch_pc, fb_taken, fb_not_taken, fb_pc, fb_target,
        output pred_valid, predicted_taken, pred_target, ready
    );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// One table write per cycle: the init sweep in INIT, feedback updates in RUN.
// Lookups read the table before that cycle's write lands (read-before-write).
// Optional feature: define BTB_PERF_CNT_EN to add lookup/hit/alloc counters.
module branch_target_buffer #(
    parameter int ENTRIES = 16,
    parameter int AWIDTH  = 30
) (
    input  logic                   clk,
    input  logic                   reset,
    branch_target_buffer_if.slave  bus
`ifdef BTB_PERF_CNT_EN
    ,
    output logic [31:0]            perf_lookups,
    output logic [31:0]            perf_hits,
    output logic [31:0]            perf_allocs
`endif
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = AWIDTH - IDX_W;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   init_idx_q, init_idx_d;
    logic               pred_valid_q, pred_valid_d;
    logic               pred_taken_q, pred_taken_d;
    logic [AWIDTH-1:0]  pred_target_q, pred_target_d;

    logic               valid_mem  [ENTRIES];
    logic [TAG_W-1:0]   tag_mem    [ENTRIES];
    logic [1:0]         cnt_mem    [ENTRIES];
    logic [AWIDTH-1:0]  target_mem [ENTRIES];

    logic [IDX_W-1:0]   lk_idx, fb_idx;
    logic [TAG_W-1:0]   lk_tag, fb_tag;
    logic               lk_taken, fb_hit;
    logic [1:0]         fb_cnt;

    logic               wr_en;
    logic [IDX_W-1:0]   wr_idx;
    logic               wr_valid;
    logic [TAG_W-1:0]   wr_tag;
    logic [1:0]         wr_cnt;
    logic [AWIDTH-1:0]  wr_target;

    // Split both PCs into index/tag and probe the table
    always_comb begin
        lk_idx   = bus.fetch_pc[IDX_W-1:0];
        lk_tag   = bus.fetch_pc[AWIDTH-1:IDX_W];
        fb_idx   = bus.fb_pc[IDX_W-1:0];
        fb_tag   = bus.fb_pc[AWIDTH-1:IDX_W];
        lk_taken = valid_mem[lk_idx] && (tag_mem[lk_idx] == lk_tag) && cnt_mem[lk_idx][1];
        fb_hit   = valid_mem[fb_idx] && (tag_mem[fb_idx] == fb_tag);
        fb_cnt   = cnt_mem[fb_idx];
    end

    // Next state, registered prediction and the single table write port
    always_comb begin
        state_d       = state_q;
        init_idx_d    = init_idx_q;
        pred_valid_d  = 1'b0;
        pred_taken_d  = 1'b0;
        pred_target_d = '0;
        wr_en         = 1'b0;
        wr_idx        = fb_idx;
        wr_valid      = 1'b1;
        wr_tag        = fb_tag;
        wr_cnt        = fb_cnt;
        wr_target     = target_mem[fb_idx];
        case (state_q)
            ST_INIT: begin
                wr_en      = 1'b1;
                wr_idx     = init_idx_q;
                wr_valid   = 1'b0;
                init_idx_d = init_idx_q + 1'b1;
                if (init_idx_q == IDX_W'(ENTRIES - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                pred_valid_d = bus.fetch_valid;
                pred_taken_d = bus.fetch_valid && lk_taken;
                if (bus.fetch_valid && lk_taken) begin
                    pred_target_d = target_mem[lk_idx];
                end
                // fb_taken takes priority if both feedback strobes are high
                if (bus.fb_taken) begin
                    wr_en     = 1'b1;
                    wr_target = bus.fb_target;
                    if (fb_hit) begin
                        wr_cnt = (fb_cnt == 2'b11) ? 2'b11 : fb_cnt + 2'b01;
                    end else begin
                        wr_cnt = 2'b10;
                    end
                end else if (bus.fb_not_taken && fb_hit) begin
                    wr_en  = 1'b1;
                    wr_cnt = (fb_cnt == 2'b00) ? 2'b00 : fb_cnt - 2'b01;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // Control and prediction registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_INIT;
            init_idx_q    <= '0;
            pred_valid_q  <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_target_q <= '0;
        end else begin
            state_q       <= state_d;
            init_idx_q    <= init_idx_d;
            pred_valid_q  <= pred_valid_d;
            pred_taken_q  <= pred_taken_d;
            pred_target_q <= pred_target_d;
        end
    end

    // Table storage: one write per cycle, none while reset is asserted
    always_ff @(posedge clk) begin
        if (reset && wr_en) begin
            valid_mem[wr_idx]  <= wr_valid;
            tag_mem[wr_idx]    <= wr_tag;
            cnt_mem[wr_idx]    <= wr_cnt;
            target_mem[wr_idx] <= wr_target;
        end
    end

    assign bus.pred_valid      = pred_valid_q;
    assign bus.predicted_taken = pred_taken_q;
    assign bus.pred_target     = pred_target_q;
    assign bus.ready           = (state_q == ST_RUN);

`ifdef BTB_PERF_CNT_EN
    logic [31:0] cnt_lookups_q, cnt_lookups_d;
    logic [31:0] cnt_hits_q, cnt_hits_d;
    logic [31:0] cnt_allocs_q, cnt_allocs_d;

    // Event counters, active only once the table is initialised
    always_comb begin
        cnt_lookups_d = cnt_lookups_q;
        cnt_hits_d    = cnt_hits_q;
        cnt_allocs_d  = cnt_allocs_q;
        if (state_q == ST_RUN) begin
            if (bus.fetch_valid) begin
                cnt_lookups_d = cnt_lookups_q + 32'd1;
            end
            if (bus.fetch_valid && lk_taken) begin
                cnt_hits_d = cnt_hits_q + 32'd1;
            end
            if (bus.fb_taken && !fb_hit) begin
                cnt_allocs_d = cnt_allocs_q + 32'd1;
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_lookups_q <= '0;
            cnt_hits_q    <= '0;
            cnt_allocs_q  <= '0;
        end else begin
            cnt_lookups_q <= cnt_lookups_d;
            cnt_hits_q    <= cnt_hits_d;
            cnt_allocs_q  <= cnt_allocs_d;
        end
    end

    assign perf_lookups = cnt_lookups_q;
    assign perf_hits    = cnt_hits_q;
    assign perf_allocs  = cnt_allocs_q;
`endif
endmodule

// File: tb/tb_branch_target_buffer.sv
// Randomised and scripted bench for branch_target_buffer against a table model
// that remembers the full PC per slot and counts direction as a bounded integer.
module tb_branch_target_buffer;
    localparam int ENTRIES = 16;
    localparam int AWIDTH  = 30;

    logic clk;
    logic reset;

    branch_target_buffer_if #(.AWIDTH(AWIDTH)) bus ();

`ifdef BTB_PERF_CNT_EN
    logic [31:0] perf_lookups, perf_hits, perf_allocs;
`endif

    branch_target_buffer #(.ENTRIES(ENTRIES), .AWIDTH(AWIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
`ifdef BTB_PERF_CNT_EN
        ,
        .perf_lookups (perf_lookups),
        .perf_hits    (perf_hits),
        .perf_allocs  (perf_allocs)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model
    bit              m_valid [ENTRIES];
    logic [AWIDTH-1:0] m_pc  [ENTRIES];
    int              m_cnt   [ENTRIES];
    logic [AWIDTH-1:0] m_tgt [ENTRIES];
    int              init_left;
    int              p_look, p_hit, p_alloc;

    int n_compared;
    int n_mismatched;
    int txn;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s (txn %0d): got %h expected %h", tag, txn, got, exp);
        end
    endtask

    task automatic step(input bit rst_n, input bit fv, input logic [AWIDTH-1:0] fpc,
                        input bit ft, input bit fnt,
                        input logic [AWIDTH-1:0] fbpc, input logic [AWIDTH-1:0] fbt);
        bit exp_pv, exp_tk, exp_rdy;
        logic [AWIDTH-1:0] exp_tgt;
        int li, fi;
        bit lhit, fhit;
        @(negedge clk);
        reset            = rst_n;
        bus.fetch_valid  = fv;
        bus.fetch_pc     = fpc;
        bus.fb_taken     = ft;
        bus.fb_not_taken = fnt;
        bus.fb_pc        = fbpc;
        bus.fb_target    = fbt;
        exp_pv  = 1'b0;
        exp_tk  = 1'b0;
        exp_tgt = '0;
        if (!rst_n) begin
            init_left = ENTRIES;
            for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
            p_look = 0; p_hit = 0; p_alloc = 0;
        end else if (init_left > 0) begin
            init_left--;
        end else begin
            li   = int'(fpc) % ENTRIES;
            fi   = int'(fbpc) % ENTRIES;
            lhit = m_valid[li] && (m_pc[li] == fpc);
            fhit = m_valid[fi] && (m_pc[fi] == fbpc);
            exp_pv = fv;
            exp_tk = fv && lhit && (m_cnt[li] >= 2);
            if (exp_tk) exp_tgt = m_tgt[li];
            if (fv) p_look++;
            if (exp_tk) p_hit++;
            if (ft) begin
                if (fhit) begin
                    m_cnt[fi] = (m_cnt[fi] + 1 > 3) ? 3 : m_cnt[fi] + 1;
                end else begin
                    m_valid[fi] = 1'b1;
                    m_pc[fi]    = fbpc;
                    m_cnt[fi]   = 2;
                    p_alloc++;
                end
                m_tgt[fi] = fbt;
            end else if (fnt && fhit) begin
                m_cnt[fi] = (m_cnt[fi] - 1 < 0) ? 0 : m_cnt[fi] - 1;
            end
        end
        exp_rdy = rst_n && (init_left == 0);
        @(posedge clk);
        #1;
        $display("txn %0d rst_n=%0b fv=%0b pc=%h ft=%0b fnt=%0b fbpc=%h fbt=%h -> pv=%0b tk=%0b tgt=%h rdy=%0b",
                 txn, rst_n, fv, fpc, ft, fnt, fbpc, fbt,
                 bus.pred_valid, bus.predicted_taken, bus.pred_target, bus.ready);
        check("pred_valid", 64'(bus.pred_valid), 64'(exp_pv));
        check("predicted_taken", 64'(bus.predicted_taken), 64'(exp_tk));
        check("pred_target", 64'(bus.pred_target), 64'(exp_tgt));
        check("ready", 64'(bus.ready), 64'(exp_rdy));
`ifdef BTB_PERF_CNT_EN
        check("perf_lookups", 64'(perf_lookups), 64'(p_look));
        check("perf_hits", 64'(perf_hits), 64'(p_hit));
        check("perf_allocs", 64'(perf_allocs), 64'(p_alloc));
`endif
        txn++;
    endtask

    task automatic look(input logic [AWIDTH-1:0] pc);
        step(1'b1, 1'b1, pc, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic fb(input bit ft, input bit fnt, input logic [AWIDTH-1:0] pc, input logic [AWIDTH-1:0] tgt);
        step(1'b1, 1'b0, '0, ft, fnt, pc, tgt);
    endtask

    task automatic do_reset_and_init();
        step(1'b0, 1'b1, 30'h100, 1'b1, 1'b0, 30'h100, 30'h55);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
        // Lookups and feedback during init must be ignored
        for (int i = 0; i < ENTRIES; i++) begin
            step(1'b1, 1'b1, 30'h100, 1'b1, 1'b0, 30'h100, 30'h77);
        end
    endtask

    function automatic logic [AWIDTH-1:0] rand_pc();
        return AWIDTH'(32'h100 + ($urandom_range(0, 3) << 4) + $urandom_range(0, 15));
    endfunction

    initial begin
        n_compared = 0; n_mismatched = 0; txn = 0;
        init_left = ENTRIES; p_look = 0; p_hit = 0; p_alloc = 0;
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0; m_pc[i] = '0; m_cnt[i] = 0; m_tgt[i] = '0;
        end
        reset = 1'b0;
        bus.fetch_valid = 1'b0; bus.fetch_pc = '0;
        bus.fb_taken = 1'b0; bus.fb_not_taken = 1'b0; bus.fb_pc = '0; bus.fb_target = '0;

        do_reset_and_init();

        // Allocate and predict
        fb(1'b1, 1'b0, 30'h100, 30'h200);
        look(30'h100);
        // Hysteresis: 2 -> 1 -> 3 -> 0
        fb(1'b0, 1'b1, 30'h100, '0);
        look(30'h100);
        fb(1'b1, 1'b0, 30'h100, 30'h200);
        fb(1'b1, 1'b0, 30'h100, 30'h200);
        look(30'h100);
        for (int i = 0; i < 3; i++) fb(1'b0, 1'b1, 30'h100, '0);
        look(30'h100);
        fb(1'b0, 1'b1, 30'h100, '0);
        fb(1'b1, 1'b0, 30'h100, 30'h210);
        look(30'h100);
        // Aliasing on the same index
        fb(1'b1, 1'b0, 30'h110, 30'h300);
        look(30'h100);
        look(30'h110);
        // Collision: lookup sees the old target, next lookup the new one
        fb(1'b1, 1'b0, 30'h100, 30'h200);
        step(1'b1, 1'b1, 30'h100, 1'b1, 1'b0, 30'h100, 30'h400);
        look(30'h100);
        // Both strobes high acts as taken
        step(1'b1, 1'b1, 30'h105, 1'b1, 1'b1, 30'h105, 30'h123);
        look(30'h105);
        // Reset mid-run, then everything misses
        do_reset_and_init();
        look(30'h100);
        look(30'h105);

        // Randomised traffic with occasional resets
        for (int n = 0; n < 400; n++) begin
            int r;
            bit ft, fnt;
            r = $urandom_range(0, 3);
            ft  = (r == 1) || (r == 3);
            fnt = (r == 2) || (r == 3);
            if ($urandom_range(0, 149) == 0) begin
                step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
            end else begin
                step(1'b1, 1'($urandom_range(0, 1)), rand_pc(), ft, fnt,
                     rand_pc(), AWIDTH'($urandom));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule

// File: doc/branch_target_buffer.md
# branch_target_buffer

Direct-mapped branch target buffer with 2-bit saturating direction counters. It sits in the frontend, directly upstream of the branch functional unit. Each cycle it looks up the fetch PC and supplies `predicted_taken` and the predicted next PC to fetch. It learns from the `fb_taken` / `fb_not_taken` / `fb_pc` / `jump_vec` feedback that the branch unit drives on `Branch_control`.

## Interface
Parameters:
- `ENTRIES`, default 16: number of table entries; power of two, ≥ 2.
- `AWIDTH`, default 30: word-address width, matching `Pu_types::Address`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset (asserted when 0).
- `fetch_valid`  in  1  lookup request this cycle.
- `fetch_pc`  in  AWIDTH  word address to look up.
- `pred_valid`  out  1  `predicted_taken` / `pred_target` are valid for the previous cycle's lookup.
- `predicted_taken`  out  1  predict taken.
- `pred_target`  out  AWIDTH  predicted target; 0 when not taken.
- `ready`  out  1  table initialised; lookups and updates are accepted.
- `fb_taken`  in  1  resolved branch was taken.
- `fb_not_taken`  in  1  resolved branch was not taken.
- `fb_pc`  in  AWIDTH  PC of the resolved instruction.
- `fb_target`  in  AWIDTH  resolved target (`jump_vec`); used only with `fb_taken`.

## Operation
- Index = `pc[log2(ENTRIES)-1:0]`. Tag = `pc[AWIDTH-1:log2(ENTRIES)]`.
- Each entry holds: `valid`, `tag`, `cnt[1:0]`, `target[AWIDTH-1:0]`. Storage is written at most once per cycle (RAM-compatible).
- FSM:
  - `INIT`: entered on reset. Clears `valid` of entry `init_idx`, then increments `init_idx`. On `init_idx == ENTRIES-1`, goes to `RUN`.
  - `RUN`: normal operation. Leaves only on reset.
- `ready` = (state == RUN).
- In `INIT`, lookups and feedback are ignored and `pred_valid` stays 0.
- Lookup (`RUN`, `fetch_valid=1`): hit = `valid && tag == fetch_pc tag`.
  - `predicted_taken` = hit && `cnt[1]`.
  - `pred_target` = `target` if taken, else 0.
- Update (`RUN`), keyed on `fb_pc`:
  - `fb_taken`, hit: `cnt` = min(`cnt`+1, 3); `target` = `fb_target`.
  - `fb_taken`, miss: allocate/overwrite the entry with `valid=1`, new tag, `cnt=2'b10`, `target=fb_target`.
  - `fb_not_taken`, hit: `cnt` = max(`cnt`-1, 0); entry stays valid.
  - `fb_not_taken`, miss: no change.
  - Both asserted (illegal): `fb_taken` wins.
- Same-cycle lookup and update on the same index: the lookup returns the pre-update contents (read-before-write). The update still commits.
- Reset mid-operation: returns to `INIT`, `init_idx=0`, and all outputs take their reset values on the next edge.

## Timing
- Reset values: `pred_valid=0`, `predicted_taken=0`, `pred_target=0`, `ready=0`. Perf counters are 0 when compiled in.
- Lookup latency is 1 cycle: `fetch_pc` sampled at edge t produces `pred_*` valid after edge t+1, registered.
- A cycle with `fetch_valid=0` clears `pred_valid` and `predicted_taken` on the next edge.
- An update at edge t is visible to a lookup sampled at edge t+1.
- Init takes exactly `ENTRIES` cycles. `ready` rises after the `ENTRIES`-th edge following the first edge with `reset=1`.
- No backpressure: every feedback pulse is consumed in its cycle.

## Configuration
- `BTB_PERF_CNT_EN` defined: adds 32-bit wrap-around counters `cnt_lookups`, `cnt_hits` (hit with `cnt[1]`), and `cnt_allocs`, incremented in `RUN` only and cleared by reset. They are exported as extra output ports `perf_lookups`, `perf_hits`, `perf_allocs`.
- `BTB_PERF_CNT_EN` undefined: counters and ports are absent; the rest of the behaviour is identical.

## Test plan
- Init: `ENTRIES=16`, release reset → `ready=0` for 16 cycles then 1. Any lookup during init gives `pred_valid=0`.
- Allocate + predict: `fb_taken`, `fb_pc=0x100`, `fb_target=0x200`. Next cycle look up 0x100 → `predicted_taken=1`, `pred_target=0x200`.
- Hysteresis: after allocation (cnt=2), one `fb_not_taken` @0x100 → cnt=1, lookup not taken. Two `fb_taken` → cnt=3. Three `fb_not_taken` → cnt=0, saturates, entry stays valid.
- Aliasing: allocate 0x100, then `fb_taken` @0x110 with target 0x300 (same index, different tag). Lookup 0x100 → not taken; lookup 0x110 → taken, target 0x300.
- Collision: lookup 0x100 in the same cycle as `fb_taken` @0x100 with new target 0x400 → that lookup returns the old target; the next lookup returns 0x400. `fb_taken=fb_not_taken=1` → treated as taken.
- Reset mid-run: assert reset after table allocations → `ready=0`, full re-init, then all lookups miss. With `BTB_PERF_CNT_EN` defined, counters read 0 and then match the scripted lookup/hit/alloc totals.
